blackjack_hand_scorer: RTL

Consumes card values (1-10) from the card random-number generator and keeps a running Blackjack hand.
- Ace is counted as 1 or 11.
- Detects bust, natural blackjack, stand and five-card limit.
- One instance per hand (player, dealer).
- Outputs feed the game FSM, the winner logic and the HEX score displays.

---
 rtl/blackjack_hand_scorer_if.sv | 26 ++
 rtl/blackjack_hand_scorer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/blackjack_hand_scorer_if.sv
// Card/score bus between the game logic and one hand scorer.
interface blackjack_hand_scorer_if;
  logic       new_hand_i;
  logic       card_valid_i;
  logic [4:0] card_value_i;
  logic       stand_i;
  logic [4:0] score_o;
  logic       soft_o;
  logic [2:0] card_count_o;
  logic       busted_o;
  logic       blackjack_o;
  logic       done_o;
  logic       err_card_o;

  // Game FSM / card source side
  modport master (
    output new_hand_i, card_valid_i, card_value_i, stand_i,
    input  score_o, soft_o, card_count_o, busted_o, blackjack_o, done_o, err_card_o
  );

  // Scorer side
  modport slave (
    input  new_hand_i, card_valid_i, card_value_i, stand_i,
    output score_o, soft_o, card_count_o, busted_o, blackjack_o, done_o, err_card_o
  );
endinterface

// File: rtl/blackjack_hand_scorer.sv
// Running Blackjack hand: accumulates cards, tracks soft aces and
// terminal conditions (stand, bust, five-card Charlie).
module blackjack_hand_scorer #(
  parameter int unsigned BUST_LIMIT = 21,
  parameter int unsigned MAX_CARDS  = 5,
  parameter int unsigned ACE_BONUS  = 10
) (
  input  logic                    clock,
  input  logic                    reset_n,
  blackjack_hand_scorer_if.slave  bus
);

  localparam int unsigned VAL_W = 5;
  localparam int unsigned SUM_W = 6;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_EMPTY   = 3'd0,
    S_ACTIVE  = 3'd1,
    S_STAND   = 3'd2,
    S_BUST    = 3'd3,
    S_CHARLIE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [VAL_W-1:0]   hard_q, hard_d;
  logic               ace_q, ace_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [VAL_W-1:0]   score_q, score_d;
  logic               soft_q, soft_d;
  logic               busted_q, busted_d;
  logic               bj_q, bj_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               card_legal;
  logic [SUM_W-1:0]   sum_add;
  logic [SUM_W-1:0]   soft_total;

  // Legal rank check and the hard total if the presented card were accepted
  always_comb begin
    card_legal = (bus.card_value_i >= VAL_W'(1)) && (bus.card_value_i <= VAL_W'(10));
    sum_add    = SUM_W'(hard_q) + SUM_W'(bus.card_value_i);
  end

  // Next-state, hand accumulation and registered-output precompute
  always_comb begin
    state_d    = state_q;
    hard_d     = hard_q;
    ace_d      = ace_q;
    count_d    = count_q;
    bj_d       = bj_q;
    err_d      = 1'b0;
    score_d    = '0;
    soft_d     = 1'b0;
    busted_d   = 1'b0;
    done_d     = 1'b0;
    soft_total = '0;

    if (bus.new_hand_i) begin
      state_d = S_EMPTY;
      hard_d  = '0;
      ace_d   = 1'b0;
      count_d = '0;
      bj_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (bus.card_valid_i) begin
            if (card_legal) begin
              state_d = S_ACTIVE;
              hard_d  = bus.card_value_i;
              ace_d   = (bus.card_value_i == VAL_W'(1));
              count_d = CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (bus.card_valid_i && card_legal) begin
            hard_d  = VAL_W'(sum_add);
            ace_d   = ace_q | (bus.card_value_i == VAL_W'(1));
            count_d = count_q + CNT_W'(1);
            if (sum_add > SUM_W'(BUST_LIMIT))
              state_d = S_BUST;
            else if (count_d == CNT_W'(MAX_CARDS))
              state_d = S_CHARLIE;
            else if (bus.stand_i)
              state_d = S_STAND;
          end else begin
            // An illegal card is dropped, but a concurrent stand still counts
            if (bus.card_valid_i) err_d = 1'b1;
            if (bus.stand_i) state_d = S_STAND;
          end
        end
        default: ;  // terminal states hold until new_hand
      endcase
    end

    // Soft adjustment: promote one ace to 11 when that does not bust
    soft_total = SUM_W'(hard_d) + SUM_W'(ACE_BONUS);
    if (ace_d && (soft_total <= SUM_W'(BUST_LIMIT))) begin
      score_d = VAL_W'(soft_total);
      soft_d  = 1'b1;
    end else begin
      score_d = hard_d;
      soft_d  = 1'b0;
    end

    // Natural: the second card lands on exactly BUST_LIMIT
    if ((count_d == CNT_W'(2)) && (count_q == CNT_W'(1)) &&
        (score_d == VAL_W'(BUST_LIMIT)) && !bus.new_hand_i)
      bj_d = 1'b1;

    busted_d = (state_d == S_BUST);
    done_d   = (state_d == S_STAND) || (state_d == S_BUST) || (state_d == S_CHARLIE);
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_EMPTY;
      hard_q   <= '0;
      ace_q    <= 1'b0;
      count_q  <= '0;
      score_q  <= '0;
      soft_q   <= 1'b0;
      busted_q <= 1'b0;
      bj_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hard_q   <= hard_d;
      ace_q    <= ace_d;
      count_q  <= count_d;
      score_q  <= score_d;
      soft_q   <= soft_d;
      busted_q <= busted_d;
      bj_q     <= bj_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.score_o      = score_q;
  assign bus.soft_o       = soft_q;
  assign bus.card_count_o = count_q;
  assign bus.busted_o     = busted_q;
  assign bus.blackjack_o  = bj_q;
  assign bus.done_o       = done_q;
  assign bus.err_card_o   = err_q;

endmodule
